// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, MEM stage FSM states, word-granular address compare.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memstate_t;

  // True when a and b agree on every bit at or above lsb.
  function automatic logic word_match(input word_t a, input word_t b, input int unsigned lsb);
    word_t diff;
    diff = (a ^ b) >> lsb;
    return (diff == '0);
  endfunction

endpackage

// File: rtl/llsc_link.sv
// Single-entry LL/SC link register: set by LL completion, cleared by matching stores or snoops.
module llsc_link
  import cpu_types_pkg::*;
#(
  parameter int unsigned MATCH_LSB = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  set,
  input  logic  st_done,
  input  word_t addr,
  input  logic  inv,
  input  word_t inv_addr,
  output logic  addr_match,
  output logic  link_v,
  output word_t link_addr
);

  logic inv_new;
  logic inv_old;

  // Compare the current op address and the snoop against the link.
  always_comb begin
    addr_match = link_v & word_match(link_addr, addr, MATCH_LSB);
    inv_new    = inv & word_match(addr, inv_addr, MATCH_LSB);
    inv_old    = inv & word_match(link_addr, inv_addr, MATCH_LSB);
  end

  // Link update; an invalidate of the word being linked this cycle wins over the set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_v    <= 1'b0;
      link_addr <= '0;
    end else if (set) begin
      link_v    <= ~inv_new;
      link_addr <= addr;
    end else if ((st_done & addr_match) | inv_old) begin
      link_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage controller: issues the latched load/store, holds it to dhit, buffers results while frozen, LL/SC.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned MATCH_LSB = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  dREN_in,
  input  logic  dWEN_in,
  input  logic  datomic_in,
  input  word_t daddr_in,
  input  word_t dstore_in,
  input  logic  advance,
  input  logic  dhit,
  input  word_t dmemload,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  mem_stall,
  output word_t mem_wdat,
  output logic  link_valid
);

  memstate_t state;
  word_t     ld_buf;
  logic      sc_pass;

  logic  op, sc, ll;
  logic  match, pass, sc_fail;
  logic  active, req, complete_now;
  logic  link_set, st_done;
  word_t sc_res;
  word_t link_addr;

  llsc_link #(.MATCH_LSB(MATCH_LSB)) u_link (
    .CLK        (CLK),
    .RST        (RST),
    .set        (link_set),
    .st_done    (st_done),
    .addr       (daddr_in),
    .inv        (ccinv),
    .inv_addr   (ccsnoopaddr),
    .addr_match (match),
    .link_v     (link_valid),
    .link_addr  (link_addr)
  );

  // Request, completion and result selection; SC pass is live in IDLE, latched afterwards.
  always_comb begin
    op           = dREN_in | dWEN_in;
    sc           = dWEN_in & datomic_in;
    ll           = dREN_in & datomic_in;
    pass         = (state == IDLE) ? match : sc_pass;
    sc_fail      = sc & ~pass;
    active       = op & (state != DONE);
    req          = active & ~sc_fail;
    complete_now = active & (dhit | sc_fail);
    link_set     = complete_now & ll;
    st_done      = complete_now & dWEN_in & ~sc_fail;
    sc_res       = word_t'(pass);

    dmemREN      = req & dREN_in;
    dmemWEN      = req & dWEN_in;
    dmemaddr     = req ? daddr_in  : '0;
    dmemstore    = req ? dstore_in : '0;
    mem_stall    = active & ~complete_now;

    if (state == DONE)  mem_wdat = ld_buf;
    else if (sc)        mem_wdat = sc_res;
    else                mem_wdat = dmemload;
  end

  // FSM: DONE holds the completed result until the pipeline advances, suppressing reissue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ld_buf  <= '0;
      sc_pass <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if ((state == IDLE) && op) sc_pass <= match;
          if (complete_now) begin
            if (advance) begin
              state <= IDLE;
            end else begin
              state  <= DONE;
              ld_buf <= sc ? sc_res : dmemload;
            end
          end else if (active) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
